vswitch_stream_hub: RTL and testbench

Packet-level AXI4-Stream hub that connects the IvSI datapath to `NUM_VSWITCH` virtual-switch instances. On ingress it demultiplexes each packet to the vSwitch selected by a vSwitch ID field in `tuser`. On egress it merges the vSwitch outputs back into one stream using packet-atomic round-robin arbitration. It is the generalised successor of the single-instance vSwitch wrapper: N channels, parametrised ID field, drop handling and a drop counter.

---
 rtl/vswitch_stream_hub.sv | 151 +++++++++++++++
 tb/tb_vswitch_stream_hub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vswitch_stream_hub.sv
// AXI4-Stream hub: packet demux from IvSI to NUM_VSWITCH vSwitch channels by tuser ID,
// and packet-atomic round-robin merge of the vSwitch outputs back to IvSI.
module vswitch_stream_hub #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_VSWITCH        = 4,
    parameter int VID_LSB            = 64,
    parameter int VID_WIDTH          = 4
) (
    input  logic                                      axis_aclk,
    input  logic                                      axis_resetn,
    // ingress from IvSI
    input  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]            s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
    input  logic                                      s_axis_tvalid,
    input  logic                                      s_axis_tlast,
    output logic                                      s_axis_tready,
    // to vSwitches
    output logic [NUM_VSWITCH*C_AXIS_DATA_WIDTH-1:0]  m_vs_axis_tdata,
    output logic [NUM_VSWITCH*C_AXIS_DATA_WIDTH/8-1:0] m_vs_axis_tkeep,
    output logic [NUM_VSWITCH*C_AXIS_TUSER_WIDTH-1:0] m_vs_axis_tuser,
    output logic [NUM_VSWITCH-1:0]                    m_vs_axis_tvalid,
    output logic [NUM_VSWITCH-1:0]                    m_vs_axis_tlast,
    input  logic [NUM_VSWITCH-1:0]                    m_vs_axis_tready,
    // from vSwitches
    input  logic [NUM_VSWITCH*C_AXIS_DATA_WIDTH-1:0]  s_vs_axis_tdata,
    input  logic [NUM_VSWITCH*C_AXIS_DATA_WIDTH/8-1:0] s_vs_axis_tkeep,
    input  logic [NUM_VSWITCH*C_AXIS_TUSER_WIDTH-1:0] s_vs_axis_tuser,
    input  logic [NUM_VSWITCH-1:0]                    s_vs_axis_tvalid,
    input  logic [NUM_VSWITCH-1:0]                    s_vs_axis_tlast,
    output logic [NUM_VSWITCH-1:0]                    s_vs_axis_tready,
    // egress to IvSI
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    output logic [31:0]                               drop_count
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH/8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int N  = NUM_VSWITCH;
    localparam int SW = $clog2(NUM_VSWITCH);

    // ---------------- ingress demux ----------------
    logic [VID_WIDTH-1:0] vid, in_sel, cur_sel;
    logic                 in_sop, in_drop, cur_drop, sel_rdy, in_acc;

    assign vid      = s_axis_tuser[VID_LSB +: VID_WIDTH];
    assign cur_sel  = in_sop ? vid : in_sel;
    assign cur_drop = in_sop ? (32'(vid) >= N) : in_drop;

    always_comb begin
        sel_rdy = 1'b0;
        for (int c = 0; c < N; c++)
            if (cur_sel == VID_WIDTH'(c)) sel_rdy = m_vs_axis_tready[c];
    end

    // drop packets are swallowed at full rate regardless of channel readiness
    assign s_axis_tready = axis_resetn && (cur_drop || sel_rdy);
    assign in_acc        = s_axis_tvalid && s_axis_tready;

    for (genvar c = 0; c < N; c++) begin : g_in
        assign m_vs_axis_tvalid[c]         = axis_resetn && s_axis_tvalid && !cur_drop &&
                                             (cur_sel == VID_WIDTH'(c));
        assign m_vs_axis_tdata[c*DW +: DW] = s_axis_tdata;
        assign m_vs_axis_tkeep[c*KW +: KW] = s_axis_tkeep;
        assign m_vs_axis_tuser[c*UW +: UW] = s_axis_tuser;
        assign m_vs_axis_tlast[c]          = s_axis_tlast;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            in_sop     <= 1'b1;
            in_sel     <= '0;
            in_drop    <= 1'b0;
            drop_count <= '0;
        end else if (in_acc) begin
            in_sop <= s_axis_tlast;
            if (in_sop && !s_axis_tlast) begin
                in_sel  <= vid;
                in_drop <= cur_drop;
            end
            if (s_axis_tlast && cur_drop && drop_count != 32'hFFFF_FFFF)
                drop_count <= drop_count + 32'd1;
        end
    end

    // ---------------- egress merge ----------------
    typedef enum logic {EG_IDLE, EG_LOCKED} eg_state_t;
    eg_state_t     eg_state;
    logic [SW-1:0] grant, last_grant, cand, eg_sel;
    logic          cand_vld, eg_vld, eg_acc;
    int            idx;

    // round-robin search starting just past the last packet's owner
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!cand_vld && s_vs_axis_tvalid[idx]) begin
                cand_vld = 1'b1;
                cand     = SW'(idx);
            end
        end
    end

    assign eg_sel = (eg_state == EG_LOCKED) ? grant : cand;
    assign eg_vld = (eg_state == EG_LOCKED) || cand_vld;

    assign m_axis_tvalid = axis_resetn && eg_vld && s_vs_axis_tvalid[eg_sel];
    assign m_axis_tdata  = s_vs_axis_tdata[int'(eg_sel)*DW +: DW];
    assign m_axis_tkeep  = s_vs_axis_tkeep[int'(eg_sel)*KW +: KW];
    assign m_axis_tuser  = s_vs_axis_tuser[int'(eg_sel)*UW +: UW];
    assign m_axis_tlast  = s_vs_axis_tlast[eg_sel];
    assign eg_acc        = m_axis_tvalid && m_axis_tready;

    for (genvar c = 0; c < N; c++) begin : g_eg
        assign s_vs_axis_tready[c] = axis_resetn && eg_vld && (eg_sel == SW'(c)) && m_axis_tready;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            eg_state   <= EG_IDLE;
            grant      <= '0;
            last_grant <= SW'(N-1);
        end else begin
            case (eg_state)
                EG_IDLE:
                    if (eg_acc) begin
                        if (m_axis_tlast) last_grant <= cand;
                        else begin
                            eg_state <= EG_LOCKED;
                            grant    <= cand;
                        end
                    end
                EG_LOCKED:
                    if (eg_acc && m_axis_tlast) begin
                        eg_state   <= EG_IDLE;
                        last_grant <= grant;
                    end
                default: eg_state <= EG_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vswitch_stream_hub.sv
// Directed bench for vswitch_stream_hub: routing, drop, backpressure, fairness,
// mid-packet reset and drop counter saturation.
module tb_vswitch_stream_hub;
    localparam int DW = 256, KW = 32, UW = 128, N = 4;

    logic axis_aclk = 1'b0, axis_resetn = 1'b0;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [N*DW-1:0] m_vs_axis_tdata, s_vs_axis_tdata;
    logic [N*KW-1:0] m_vs_axis_tkeep, s_vs_axis_tkeep;
    logic [N*UW-1:0] m_vs_axis_tuser, s_vs_axis_tuser;
    logic [N-1:0]    m_vs_axis_tvalid, m_vs_axis_tlast, m_vs_axis_tready;
    logic [N-1:0]    s_vs_axis_tvalid, s_vs_axis_tlast, s_vs_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]     drop_count;

    int n_chk = 0, n_err = 0;
    int pb[N];
    int ecnt[N];
    int exp_ch[12] = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};

    vswitch_stream_hub dut (
        .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_vs_axis_tdata(m_vs_axis_tdata), .m_vs_axis_tkeep(m_vs_axis_tkeep),
        .m_vs_axis_tuser(m_vs_axis_tuser), .m_vs_axis_tvalid(m_vs_axis_tvalid),
        .m_vs_axis_tlast(m_vs_axis_tlast), .m_vs_axis_tready(m_vs_axis_tready),
        .s_vs_axis_tdata(s_vs_axis_tdata), .s_vs_axis_tkeep(s_vs_axis_tkeep),
        .s_vs_axis_tuser(s_vs_axis_tuser), .s_vs_axis_tvalid(s_vs_axis_tvalid),
        .s_vs_axis_tlast(s_vs_axis_tlast), .s_vs_axis_tready(s_vs_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .drop_count(drop_count)
    );

    always #5 axis_aclk = ~axis_aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic in_beat(input int vid, input int d, input logic last);
        s_axis_tvalid      = 1'b1;
        s_axis_tdata       = DW'(d);
        s_axis_tuser       = '0;
        s_axis_tuser[64 +: 4] = 4'(vid);
        s_axis_tlast       = last;
        #1;
    endtask

    task automatic drive_vs();
        for (int i = 0; i < N; i++) begin
            s_vs_axis_tdata[i*DW +: DW] = DW'(i*256 + pb[i]);
            s_vs_axis_tlast[i]          = (pb[i] % 2) == 1;
        end
    endtask

    initial begin
        s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tuser = '0;
        s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        s_vs_axis_tdata = '0; s_vs_axis_tkeep = '1; s_vs_axis_tuser = '0;
        s_vs_axis_tlast = '0; s_vs_axis_tvalid = '1;
        m_vs_axis_tready = '1; m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) begin pb[i] = 0; ecnt[i] = 0; end

        // reset state with all inputs pushing
        #3;
        chk("rst_m_vs_vld", m_vs_axis_tvalid, 0);
        chk("rst_s_rdy", s_axis_tready, 0);
        chk("rst_s_vs_rdy", s_vs_axis_tready, 0);
        chk("rst_m_vld", m_axis_tvalid, 0);
        chk("rst_drop", drop_count, 0);
        s_axis_tvalid = 1'b0; s_vs_axis_tvalid = '0;
        step(); step();
        axis_resetn = 1'b1;
        step();

        // routing: 3-beat packet vid=2, later beats carry a different vid
        for (int b = 0; b < 3; b++) begin
            in_beat(b == 0 ? 2 : 0, 16'hA0 + b, b == 2);
            chk("route_vld", m_vs_axis_tvalid, 4'b0100);
            chk("route_rdy", s_axis_tready, 1);
            chk("route_data", m_vs_axis_tdata[2*DW +: 16], 16'hA0 + b);
            chk("route_last", m_vs_axis_tlast[2], b == 2);
            step();
        end

        // drop: vid=5 2-beat packet with no channel ready, then vid=1
        m_vs_axis_tready = '0;
        in_beat(5, 1, 1'b0);
        chk("drop_vld0", m_vs_axis_tvalid, 0);
        chk("drop_rdy0", s_axis_tready, 1);
        step();
        chk("drop_cnt_mid", drop_count, 0);
        in_beat(1, 2, 1'b1);
        chk("drop_vld1", m_vs_axis_tvalid, 0);
        chk("drop_rdy1", s_axis_tready, 1);
        step();
        chk("drop_cnt_end", drop_count, 1);
        m_vs_axis_tready = '1;
        in_beat(1, 3, 1'b1);
        chk("post_drop_vld", m_vs_axis_tvalid, 4'b0010);
        chk("post_drop_rdy", s_axis_tready, 1);
        step();
        chk("post_drop_cnt", drop_count, 1);

        // backpressure on channel 0 for 5 cycles mid-packet
        in_beat(0, 16'hB0, 1'b0);
        step();
        m_vs_axis_tready = 4'b1110;
        in_beat(3, 16'hB1, 1'b0);
        for (int t = 0; t < 5; t++) begin
            chk("bp_stall_rdy", s_axis_tready, 0);
            chk("bp_stall_vld", m_vs_axis_tvalid, 4'b0001);
            step();
        end
        m_vs_axis_tready = '1;
        #1;
        chk("bp_resume_rdy", s_axis_tready, 1);
        chk("bp_resume_data", m_vs_axis_tdata[15:0], 16'hB1);
        step();
        in_beat(3, 16'hB2, 1'b1);
        chk("bp_last_vld", m_vs_axis_tvalid, 4'b0001);
        chk("bp_last_data", m_vs_axis_tdata[15:0], 16'hB2);
        step();
        s_axis_tvalid = 1'b0;

        // fairness: channels 0,1,3 always offer 2-beat packets
        s_vs_axis_tvalid = 4'b1011;
        for (int t = 0; t < 12; t++) begin
            int c;
            c = exp_ch[t];
            drive_vs();
            #1;
            chk("eg_vld", m_axis_tvalid, 1);
            chk("eg_data", m_axis_tdata[15:0], 64'(c*256 + ecnt[c]));
            chk("eg_last", m_axis_tlast, 64'(ecnt[c] % 2));
            chk("eg_rdy", s_vs_axis_tready, 64'(1 << c));
            for (int i = 0; i < N; i++)
                if (s_vs_axis_tvalid[i] && s_vs_axis_tready[i]) pb[i]++;
            ecnt[c]++;
            step();
        end
        s_vs_axis_tvalid = '0;

        // reset mid-packet on both paths
        pb[1] = 0; pb[2] = 0;
        s_vs_axis_tdata[1*DW +: DW] = DW'(16'h1100);
        s_vs_axis_tlast = '0;
        s_vs_axis_tvalid = 4'b0010;
        in_beat(3, 16'hC0, 1'b0);
        chk("rm_in_vld", m_vs_axis_tvalid, 4'b1000);
        chk("rm_eg_rdy", s_vs_axis_tready, 4'b0010);
        step(); step();
        s_axis_tvalid = 1'b1;
        axis_resetn = 1'b0;
        #1;
        chk("rm_m_vld", m_axis_tvalid, 0);
        chk("rm_s_vs_rdy", s_vs_axis_tready, 0);
        chk("rm_m_vs_vld", m_vs_axis_tvalid, 0);
        chk("rm_s_rdy", s_axis_tready, 0);
        step();
        axis_resetn = 1'b1;
        s_vs_axis_tvalid = 4'b0100;
        s_vs_axis_tdata[2*DW +: DW] = DW'(16'h2200);
        s_vs_axis_tlast = 4'b0100;
        in_beat(1, 16'hC1, 1'b1);
        chk("rm_post_eg_vld", m_axis_tvalid, 1);
        chk("rm_post_eg_rdy", s_vs_axis_tready, 4'b0100);
        chk("rm_post_eg_data", m_axis_tdata[15:0], 16'h2200);
        chk("rm_post_in_vld", m_vs_axis_tvalid, 4'b0010);
        step();
        s_vs_axis_tvalid = '0;

        // saturation
        force dut.drop_count = 32'hFFFF_FFFE;
        #1;
        release dut.drop_count;
        chk("sat_preload", drop_count, 32'hFFFF_FFFE);
        for (int p = 0; p < 3; p++) begin
            in_beat(7, p, 1'b1);
            step();
            chk("sat_cnt", drop_count, 32'hFFFF_FFFF);
        end
        s_axis_tvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
